ula_sequencer: RTL

ULA_SEQUENCER -- requirements
Module: ula_sequencer

---
 rtl/ula_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/ula_sequencer.sv
// Sequencer for the matrix ALU: hands one operation at a time to a unit, waits
// for its done level (or a timeout), registers the result and pulses done/error.
module ula_sequencer #(
  parameter int DATA_W  = 200,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        opcode,
  output logic              op_ready,
  output logic [6:0]        unit_start,
  output logic [2:0]        unit_sel,
  input  logic [6:0]        unit_done,
  input  logic [DATA_W-1:0] result_in,
  output logic [DATA_W-1:0] result_out,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic [7:0]        cycles_last
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       done_pad;
  logic [7:0]       start_dec;
  logic             sel_done;
  logic             timeout_hit;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  assign op_ready    = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign cnt_nxt     = cnt + 1'b1;
  // Pad to 8 bits so the illegal index 7 reads as "not done" instead of out of range.
  assign done_pad    = {1'b0, unit_done};
  assign sel_done    = done_pad[unit_sel];
  assign start_dec   = 8'b1 << opcode;
  assign timeout_hit = (32'(cnt_nxt) == 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      unit_start  <= '0;
      unit_sel    <= '0;
      result_out  <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      cycles_last <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            unit_sel <= opcode;
            cnt      <= '0;
            if (opcode == OP_ILLEGAL) begin
              state       <= ST_RELEASE;
              done        <= 1'b1;
              error       <= 1'b1;
              cycles_last <= '0;
            end else begin
              state      <= ST_WAIT;
              unit_start <= start_dec[6:0];
            end
          end
        end
        ST_WAIT: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (sel_done) begin
            result_out  <= result_in;
            unit_start  <= '0;
            done        <= 1'b1;
            error       <= 1'b0;
            cycles_last <= sat8(32'(cnt_nxt));
            state       <= ST_RELEASE;
          end else if (timeout_hit) begin
            result_out  <= '0;
            unit_start  <= '0;
            done        <= 1'b1;
            error       <= 1'b1;
            cycles_last <= sat8(32'(TIMEOUT));
            state       <= ST_RELEASE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          unit_start <= '0;
          done       <= 1'b0;
          error      <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
